muldiv_unit: RTL and testbench

Iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core. It sits beside the EX-stage ALU and accepts MULT/MULTU/DIV/DIVU from the decoded instruction stream. It runs the operation over multiple cycles and raises a stall request to the hazard logic when a later instruction needs HI/LO, or issues a new mul/div, while the unit is busy. It also executes MTHI/MTLO writes.

---
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers for the MIPS EX stage.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish as soon as the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hilo_read,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t state, state_nxt;

    // acc: product (mul) or {remainder, quotient} (div); opa: shifted multiplicand or divisor
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] opa;
    logic [WIDTH-1:0]   opb;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               no_wr;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        mag_a;
    logic [WIDTH-1:0]        mag_b;
    logic                    div_zero;
    logic                    last_step;

    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic               rem_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    function automatic logic [WIDTH-1:0] abs_w(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    assign a_s      = src_a;
    assign b_s      = src_b;
    // Unsigned magnitudes cover the 0x80000000 corner without an extra bit
    assign mag_a    = op[0] ? src_a : abs_w(a_s);
    assign mag_b    = op[0] ? src_b : abs_w(b_s);
    assign div_zero = op[1] && (src_b == '0);

    assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    assign rem_ge   = rem_sh >= {1'b0, opa[WIDTH-1:0]};
    assign rem_diff = rem_sh - {1'b0, opa[WIDTH-1:0]};

    assign prod_fix = cond_neg_2w(acc, neg_q);
    assign quot_fix = cond_neg_w(acc[WIDTH-1:0], neg_q);
    assign rem_fix  = cond_neg_w(acc[2*WIDTH-1:WIDTH], neg_r);

`ifdef MULDIV_EARLY_OUT_EN
    assign last_step = (cnt == '1) || (!is_div && (opb[WIDTH-1:1] == '0));
`else
    assign last_step = (cnt == '1);
`endif

    assign busy  = (state != IDLE);
    assign stall = busy && (start || hilo_read || hi_we || lo_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = div_zero ? FIX : ITER;
                end
            end
            ITER: begin
                if (last_step) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            no_wr  <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        // squashed cycle: neither the issue nor an MTHI/MTLO takes effect
                    end else if (start) begin
                        is_div <= op[1];
                        neg_q  <= !op[0] && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_r  <= !op[0] && src_a[WIDTH-1];
                        no_wr  <= div_zero;
                        cnt    <= '0;
                        opb    <= mag_b;
                        if (op[1]) begin
                            acc <= {{WIDTH{1'b0}}, mag_a};
                            opa <= {{WIDTH{1'b0}}, mag_b};
                        end else begin
                            acc <= '0;
                            opa <= {{WIDTH{1'b0}}, mag_a};
                        end
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                ITER: begin
                    cnt <= cnt + CNT_W'(1);
                    if (is_div) begin
                        if (rem_ge) begin
                            acc <= {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= acc + (opb[0] ? opa : '0);
                        opa <= opa << 1;
                        opb <= opb >> 1;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (!no_wr) begin
                            if (is_div) begin
                                hi <= rem_fix;
                                lo <= quot_fix;
                            end else begin
                                hi <= prod_fix[2*WIDTH-1:WIDTH];
                                lo <= prod_fix[WIDTH-1:0];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: results, busy/done timing, stall, flush, reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        hilo_read;
    logic        flush;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] exp_q[$];
    int          busy_q[$];
    string       tag_q[$];
    logic [63:0] exp_hl;

    muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hilo_read(hilo_read), .flush(flush),
        .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] prev);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: p = 64'(sa * sb);
            2'd1: p = {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == 0) return prev;
                q = sa / sb;
                r = sa % sb;
                p = {32'(r), 32'(q)};
            end
            default: begin
                if (b == 0) return prev;
                p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    function automatic int model_busy(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] m;
        int n;
        m = b;
        n = 1;
        if (o[1] && b == 0) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[1]) begin
            if (o == 2'd0 && b[31]) m = -b;
            for (int k = 1; k < 32; k++) if ((m >> k) != 0) n = k + 1;
            return n + 1;
        end
`endif
        return 33;
    endfunction

    // Called just after a falling edge; returns just after the falling edge following T0.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit track, input string tag);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        if (track) begin
            exp_hl = model(o, a, b, exp_hl);
            exp_q.push_back(exp_hl);
            busy_q.push_back(model_busy(o, b));
            tag_q.push_back(tag);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode: 0 quiet, 1 hilo_read, 2 lo_we (must be ignored), 3 start (must be ignored)
    task automatic collect(input int mode);
        int n;
        int eb;
        logic [63:0] e;
        string t;
        n = 0;
        e = exp_q.pop_front();
        eb = busy_q.pop_front();
        t = tag_q.pop_front();
        case (mode)
            1: hilo_read = 1'b1;
            2: begin lo_we = 1'b1; wdata = 32'hDEAD_BEEF; end
            3: begin start = 1'b1; op = 2'd1; src_a = 32'h1111; src_b = 32'h2; end
            default: ;
        endcase
        #1;
        while (busy === 1'b1 && n <= 40) begin
            if (mode != 0) check({t, "_stall_busy"}, 64'(stall), 64'd1);
            n++;
            @(negedge clk);
            #1;
        end
        check({t, "_busy_cycles"}, 64'(n), 64'(eb));
        check({t, "_done"}, 64'(done), 64'd1);
        if (mode != 0) check({t, "_stall_done"}, 64'(stall), 64'd0);
        check({t, "_hilo"}, {hi, lo}, e);
        hilo_read = 1'b0;
        lo_we     = 1'b0;
        start     = 1'b0;
        @(negedge clk);
        #1;
        check({t, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0; hilo_read = 1'b1; flush = 1'b0;
        exp_hl = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        hilo_read = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1, "multu_max");
        collect(1);
        issue(2'd0, 32'hFFFF_FFFD, 32'd5, 1, "mult_neg");
        collect(0);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1, "div_neg");
        collect(0);
        issue(2'd3, 32'd100, 32'd7, 1, "divu");
        collect(0);

        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        exp_hl[63:32] = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        #1;
        check("mthi", {hi, lo}, exp_hl);
        issue(2'd3, 32'd55, 32'd0, 1, "divu_zero");
        collect(1);

        issue(2'd3, 32'd100, 32'd7, 0, "divu_flush");
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hilo", {hi, lo}, exp_hl);
        issue(2'd0, 32'h8000_0000, 32'h8000_0000, 1, "mult_minmin");
        collect(0);

        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, "div_ovf");
        collect(2);
        issue(2'd1, 32'h1357_9BDF, 32'd1, 1, "multu_one");
        collect(3);
        issue(2'd0, 32'h7FFF_FFFF, 32'd0, 1, "mult_zero");
        collect(0);
        issue(2'd0, 32'h0001_2345, 32'hFFFF_0003, 1, "mult_mix");
        collect(0);

        issue(2'd1, 32'd6, 32'd7, 0, "reset_mid");
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_hl = '0;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hilo", {hi, lo}, exp_hl);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'd1, 32'd6, 32'd7, 1, "multu_after_rst");
        collect(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
